// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key-entry path: key codes, FSM states
// and the default operand length.
package calc_pkg;

    localparam int DIGITS_DEF = 3;

    localparam logic [3:0] KEY_ADD = 4'ha;
    localparam logic [3:0] KEY_SUB = 4'hb;
    localparam logic [3:0] KEY_MUL = 4'hc;
    localparam logic [3:0] KEY_DIV = 4'hd;
    localparam logic [3:0] KEY_EQ  = 4'he;
    localparam logic [3:0] KEY_CLR = 4'hf;

    typedef enum logic [2:0] {
        ST_OP1,
        ST_OP2,
        ST_EVAL,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

endpackage

// File: rtl/bcd_shift_reg.sv
// One BCD operand: shifts digits in from the least significant end and
// saturates once DIGITS digits are held.
module bcd_shift_reg
    import calc_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         load,
    input  logic [3:0]                   digit,
    output logic [4*DIGITS-1:0]          value,
    output logic [$clog2(DIGITS+1)-1:0]  cnt,
    output logic                         zero
);

    localparam int CNT_W = $clog2(DIGITS + 1);

    // clr together with load restarts the operand with this digit as its first
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            cnt   <= '0;
        end else if (clr) begin
            if (load) begin
                value <= {{(4*DIGITS-4){1'b0}}, digit};
                cnt   <= CNT_W'(1);
            end else begin
                value <= '0;
                cnt   <= '0;
            end
        end else if (load && (cnt < CNT_W'(DIGITS))) begin
            value <= {value[4*DIGITS-5:0], digit};
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/calc_entry_ctrl.sv
// Key-entry sequencer: builds two BCD operands and an operator from key codes,
// strobes the arithmetic block on '=' and flags the result after EVAL_LAT clocks.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int DIGITS   = DIGITS_DEF,
    parameter int EVAL_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          key_code,
    input  logic                key_valid,
    output logic [4*DIGITS-1:0] num_reg1,
    output logic [4*DIGITS-1:0] num_reg2,
    output logic [3:0]          sym,
    output logic                eval_flag,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                entry_sel
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int LAT_W = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;

    state_t             state, state_n;
    logic [LAT_W-1:0]   lat_cnt, lat_n;
    logic [3:0]         sym_n;
    logic               eval_n, busy_n, done_n, err_n, entry_n;
    logic               clr_ops, ld1, ld2, wipe;
    logic [CNT_W-1:0]   cnt1, cnt2;
    logic               zero1, zero2;

    bcd_shift_reg #(.DIGITS(DIGITS)) u_op1 (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_ops),
        .load  (ld1),
        .digit (key_code),
        .value (num_reg1),
        .cnt   (cnt1),
        .zero  (zero1)
    );

    bcd_shift_reg #(.DIGITS(DIGITS)) u_op2 (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_ops),
        .load  (ld2),
        .digit (key_code),
        .value (num_reg2),
        .cnt   (cnt2),
        .zero  (zero2)
    );

    // operand-1 status is not needed by the sequencer
    logic unused_op1;
    assign unused_op1 = ^{cnt1, zero1};

    always_comb begin
        state_n = state;
        lat_n   = lat_cnt;
        sym_n   = sym;
        eval_n  = 1'b0;
        busy_n  = busy;
        done_n  = done;
        err_n   = err;
        entry_n = entry_sel;
        clr_ops = 1'b0;
        ld1     = 1'b0;
        ld2     = 1'b0;
        wipe    = 1'b0;
        unique case (state)
            ST_OP1: if (key_valid) begin
                if (is_digit(key_code)) begin
                    ld1 = 1'b1;
                end else if (is_op(key_code)) begin
                    sym_n   = key_code;
                    entry_n = 1'b1;
                    state_n = ST_OP2;
                end else if (key_code == KEY_CLR) begin
                    wipe = 1'b1;
                end
            end
            ST_OP2: if (key_valid) begin
                if (is_digit(key_code)) begin
                    ld2 = 1'b1;
                end else if (is_op(key_code)) begin
                    if (cnt2 == '0) sym_n = key_code;
                end else if (key_code == KEY_EQ) begin
                    if (cnt2 != '0) begin
                        if ((sym == KEY_DIV) && zero2) begin
                            err_n   = 1'b1;
                            state_n = ST_DONE;
                        end else begin
                            eval_n  = 1'b1;
                            busy_n  = 1'b1;
                            state_n = ST_EVAL;
                        end
                    end
                end else begin
                    wipe = 1'b1;
                end
            end
            ST_EVAL: begin
                lat_n   = LAT_W'(EVAL_LAT - 1);
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt == '0) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_DONE;
                end else begin
                    lat_n = lat_cnt - LAT_W'(1);
                end
            end
            ST_DONE: if (key_valid) begin
                if (is_digit(key_code)) begin
                    wipe = 1'b1;
                    ld1  = 1'b1;
                end else if (is_op(key_code)) begin
                    clr_ops = 1'b1;
                    sym_n   = key_code;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                    entry_n = 1'b1;
                    state_n = ST_OP2;
                end else if (key_code == KEY_CLR) begin
                    wipe = 1'b1;
                end
            end
            default: state_n = ST_OP1;
        endcase
        if (wipe) begin
            clr_ops = 1'b1;
            sym_n   = '0;
            done_n  = 1'b0;
            err_n   = 1'b0;
            entry_n = 1'b0;
            busy_n  = 1'b0;
            state_n = ST_OP1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_OP1;
            lat_cnt   <= '0;
            sym       <= '0;
            eval_flag <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            entry_sel <= 1'b0;
        end else begin
            state     <= state_n;
            lat_cnt   <= lat_n;
            sym       <= sym_n;
            eval_flag <= eval_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            entry_sel <= entry_n;
        end
    end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl with hand-computed expected values.
module tb_calc_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key_code = 4'h0;
    logic        key_valid = 1'b0;
    logic [11:0] num_reg1, num_reg2;
    logic [3:0]  sym;
    logic        eval_flag, busy, done, err, entry_sel;

    int checks = 0;
    int failures = 0;
    int eval_cnt = 0;
    int eval_snap;

    calc_entry_ctrl #(.DIGITS(3), .EVAL_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_code  (key_code),
        .key_valid (key_valid),
        .num_reg1  (num_reg1),
        .num_reg2  (num_reg2),
        .sym       (sym),
        .eval_flag (eval_flag),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .entry_sel (entry_sel)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (eval_flag) eval_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_code  = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_n1"}, num_reg1, 12'h000);
        check({tag, "_n2"}, num_reg2, 12'h000);
        check({tag, "_flags"}, {sym, eval_flag, busy, done, err, entry_sel}, 9'h000);
    endtask

    initial begin
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();

        // 123 + 045
        press(4'h1); press(4'h2); press(4'h3);
        check("op1_123", num_reg1, 12'h123);
        check("sel_op1", entry_sel, 1'b0);
        press(4'he);
        check("eq_in_op1_ignored", {eval_flag, busy}, 2'b00);
        press(4'ha);
        check("sym_add", sym, 4'ha);
        check("sel_op2", entry_sel, 1'b1);
        press(4'h4); press(4'h5);
        check("op2_045", num_reg2, 12'h045);
        press(4'he);
        check("strobe", {eval_flag, busy, done}, 3'b110);
        tick();
        check("eval_wait", {eval_flag, busy, done}, 3'b010);
        tick();
        check("done", {eval_flag, busy, done}, 3'b001);
        check("hold_ops", {num_reg1, num_reg2, sym}, {12'h123, 12'h045, 4'ha});
        check("one_strobe", eval_cnt, 1);

        // saturation
        press(4'hf);
        check_idle("clear");
        press(4'h9); press(4'h8); press(4'h7); press(4'h6);
        check("sat_987", num_reg1, 12'h987);

        // divide by zero
        press(4'hf);
        eval_snap = eval_cnt;
        press(4'h7); press(4'hd); press(4'h0); press(4'he);
        tick();
        check("dz_flags", {busy, done, err}, 3'b001);
        check("dz_no_strobe", eval_cnt, eval_snap);
        press(4'h5);
        check("dz_recover", {num_reg1, num_reg2, sym, err, entry_sel}, {12'h005, 12'h000, 4'h0, 1'b0, 1'b0});

        // operator replace, keys dropped while busy
        press(4'hf);
        press(4'h2); press(4'ha); press(4'hb);
        check("sym_replace", sym, 4'hb);
        press(4'h3); press(4'ha);
        check("no_chain", sym, 4'hb);
        press(4'he);
        check("strobe2", eval_flag, 1'b1);
        press(4'h3);
        check("busy_drop", {busy, num_reg2}, {1'b1, 12'h003});
        press(4'hf);
        check("drop_ops", {num_reg1, num_reg2, sym, done}, {12'h002, 12'h003, 4'hb, 1'b1});

        // operator straight after done
        press(4'hc);
        check("done_op", {num_reg1, num_reg2, sym, entry_sel, done}, {12'h000, 12'h000, 4'hc, 1'b1, 1'b0});
        press(4'h4); press(4'he);
        check("done_op_eval", {eval_flag, num_reg2}, {1'b1, 12'h004});
        tick(); tick();
        check("done_op_done", done, 1'b1);

        // reset beats a coincident key
        press(4'hf);
        press(4'h1); press(4'ha); press(4'h2);
        eval_snap = eval_cnt;
        @(negedge clk);
        rst = 1'b1;
        key_code = 4'he;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        rst = 1'b0;
        check_idle("rst_key");
        tick(); tick();
        check("rst_no_strobe", eval_cnt, eval_snap);
        press(4'h3);
        check("after_rst_op1", {num_reg1, entry_sel}, {12'h003, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
